// File: rtl/mux_arb_pkg.sv
// Shared definitions for the N:1 arbitrating mux: mode encodings,
// lock FSM state type and the select-width helper.
package mux_arb_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } lock_state_e;

    // Index width for n channels; never below one bit so the port always exists.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mux_arb_nx1_if.sv
// Channel bundle for mux_arb_nx1. The master side produces the source beats
// and consumes the result; the slave side is the mux itself.
// in_last exists only when MUX_ARB_LOCK_EN is defined.
interface mux_arb_nx1_if
    import mux_arb_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int N     = 4
);
    localparam int SELW = clog2_min1(N);

    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_ready;
`ifdef MUX_ARB_LOCK_EN
    logic [N-1:0]       in_last;
`endif
    logic               mode;
    logic [SELW-1:0]    sel;
    logic [WIDTH-1:0]   out_data;
    logic [SELW-1:0]    out_src;
    logic               out_valid;
    logic               out_ready;

    modport master (
`ifdef MUX_ARB_LOCK_EN
        output in_last,
`endif
        output in_data, in_valid, mode, sel, out_ready,
        input  in_ready, out_data, out_src, out_valid
    );

    modport slave (
`ifdef MUX_ARB_LOCK_EN
        input  in_last,
`endif
        input  in_data, in_valid, mode, sel, out_ready,
        output in_ready, out_data, out_src, out_valid
    );

endinterface

// File: rtl/mux_arb_nx1_rr_pick.sv
// Rotate-priority finder: returns the first requesting index at or above
// ptr, wrapping from N-1 back to 0.
module rr_pick
    import mux_arb_pkg::*;
#(
    parameter int  N    = 4,
    localparam int SELW = clog2_min1(N)
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] ptr,
    output logic [SELW-1:0] gnt_idx,
    output logic            gnt_any
);

    logic [2*N-1:0]  req2_s;
    logic [N-1:0]    rot_s;
    logic [SELW-1:0] off_s;
    logic [SELW:0]   sum_s;

    // Rotate requests so ptr sits at bit 0, take the lowest set bit, rotate back.
    always_comb begin
        req2_s = {req, req};
        rot_s  = req2_s[ptr +: N];
        off_s  = {SELW{1'b0}};
        for (int j = N - 1; j >= 0; j--) begin
            off_s = rot_s[j] ? SELW'(j) : off_s;
        end
        sum_s   = {1'b0, ptr} + {1'b0, off_s};
        gnt_idx = (sum_s >= (SELW+1)'(N)) ? SELW'(sum_s - (SELW+1)'(N)) : sum_s[SELW-1:0];
        gnt_any = |req;
    end

endmodule

// File: rtl/mux_arb_nx1.sv
// N:1 datapath mux with registered output and valid/ready handshake.
// mode=0 picks the channel on sel, mode=1 arbitrates round-robin.
// Optional feature: define MUX_ARB_LOCK_EN to hold the grant on one channel
// until it delivers a beat with in_last set.
module mux_arb_nx1
    import mux_arb_pkg::*;
#(
    parameter int  WIDTH = 8,
    parameter int  N     = 4,
    localparam int SELW  = clog2_min1(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    mux_arb_nx1_if.slave bus
);

    logic [WIDTH-1:0] out_data_r;
    logic [SELW-1:0]  out_src_r;
    logic             out_valid_r;
    logic [SELW-1:0]  rr_ptr_r;

    logic [WIDTH-1:0] ch_data_s [N];
    logic             load_s;
    logic             fix_any_s;
    logic [SELW-1:0]  rr_idx_s;
    logic             rr_any_s;
    logic [SELW-1:0]  arb_idx_s;
    logic             arb_any_s;
    logic [SELW-1:0]  gnt_idx_s;
    logic             gnt_any_s;
    logic             accept_s;
    logic             adv_s;
    logic [SELW-1:0]  ptr_next_s;

    for (genvar i = 0; i < N; i++) begin : g_unpack
        assign ch_data_s[i] = bus.in_data[i*WIDTH +: WIDTH];
    end

    rr_pick #(.N(N)) u_rr_pick (
        .req     (bus.in_valid),
        .ptr     (rr_ptr_r),
        .gnt_idx (rr_idx_s),
        .gnt_any (rr_any_s)
    );

    assign load_s    = ~out_valid_r | bus.out_ready;
    assign fix_any_s = (int'(bus.sel) < N) ? bus.in_valid[bus.sel] : 1'b0;

    // Mode-dependent candidate before any lock override.
    always_comb begin
        arb_idx_s = bus.sel;
        arb_any_s = fix_any_s;
        if (bus.mode == MODE_RR) begin
            arb_idx_s = rr_idx_s;
            arb_any_s = rr_any_s;
        end else begin
            arb_idx_s = bus.sel;
            arb_any_s = fix_any_s;
        end
    end

`ifdef MUX_ARB_LOCK_EN
    lock_state_e     state_r, state_nx;
    logic [SELW-1:0] lock_ch_r, lock_ch_nx;

    // While locked, the held channel owns the grant whatever mode/sel say.
    always_comb begin
        gnt_idx_s = arb_idx_s;
        gnt_any_s = arb_any_s;
        if (state_r == ST_LOCKED) begin
            gnt_idx_s = lock_ch_r;
            gnt_any_s = bus.in_valid[lock_ch_r];
        end else begin
            gnt_idx_s = arb_idx_s;
            gnt_any_s = arb_any_s;
        end
    end

    // Lock FSM next state: enter on a non-last beat, leave on the last one.
    always_comb begin
        state_nx   = state_r;
        lock_ch_nx = lock_ch_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s && !bus.in_last[gnt_idx_s]) begin
                    state_nx   = ST_LOCKED;
                    lock_ch_nx = gnt_idx_s;
                end else begin
                    state_nx   = ST_IDLE;
                end
            end
            ST_LOCKED: begin
                if (accept_s && bus.in_last[lock_ch_r]) begin
                    state_nx = ST_IDLE;
                end else begin
                    state_nx = ST_LOCKED;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Lock FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            lock_ch_r <= {SELW{1'b0}};
        end else begin
            state_r   <= state_nx;
            lock_ch_r <= lock_ch_nx;
        end
    end

    assign adv_s = accept_s & (bus.mode == MODE_RR) & (state_nx == ST_IDLE);
`else
    assign gnt_idx_s = arb_idx_s;
    assign gnt_any_s = arb_any_s;
    assign adv_s     = accept_s & (bus.mode == MODE_RR);
`endif

    assign accept_s   = load_s & gnt_any_s;
    assign ptr_next_s = (gnt_idx_s == SELW'(N - 1)) ? {SELW{1'b0}} : gnt_idx_s + SELW'(1);

    // Only the granted channel sees ready, and never while reset is held.
    assign bus.in_ready = (accept_s & rst_n) ? ({{(N-1){1'b0}}, 1'b1} << gnt_idx_s) : {N{1'b0}};

    // Output beat register: capture on accept, drain to empty when nothing is granted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_r  <= {WIDTH{1'b0}};
            out_src_r   <= {SELW{1'b0}};
            out_valid_r <= 1'b0;
        end else if (accept_s) begin
            out_data_r  <= ch_data_s[gnt_idx_s];
            out_src_r   <= gnt_idx_s;
            out_valid_r <= 1'b1;
        end else if (load_s) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    // Round-robin pointer moves past the winner of each arbitrated beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_r <= {SELW{1'b0}};
        end else if (adv_s) begin
            rr_ptr_r <= ptr_next_s;
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end

    assign bus.out_data  = out_data_r;
    assign bus.out_src   = out_src_r;
    assign bus.out_valid = out_valid_r;

endmodule
